// File: rtl/apb_master_arbiter_if.sv
// APB bus bundle between apb_master_arbiter (master modport) and the UART register slave.
interface apb_master_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int PSEL_W = 16
);
  logic [ADDR_W-1:0] PADDR;
  logic [PSEL_W-1:0] PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// Two-requester round-robin APB master sharing one bus toward the UART register slave.
// Optional ACCESS wait-state timeout is enabled by defining APB_TIMEOUT_EN.
module apb_master_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int PSEL_W    = 16,
  parameter int SLV_IDX   = 0,
  parameter int TO_CYCLES = 64
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic [1:0]          req,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          done,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  apb_master_arbiter_if.master apb
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  localparam logic [PSEL_W-1:0] SEL_ONEHOT = PSEL_W'(1) << SLV_IDX;

  if (SLV_IDX < 0 || SLV_IDX >= PSEL_W || TO_CYCLES < 1) begin : g_bad_params
    $error("apb_master_arbiter: illegal parameter combination");
  end

  logic [1:0] state;
  logic       rr_ptr;
  logic       win_idx;
  logic [1:0] idle_req;
  logic [1:0] exit_req;
  logic [1:0] cand;
  logic       pick;
  logic       xfer_end;
  logic       do_grant;

  // A requester still sees its own done pulse for one cycle, so its req is masked then.
  always_comb begin
    idle_req = req & ~done;
    exit_req = req & ~(2'b01 << win_idx);
    cand     = (state == ST_IDLE) ? idle_req : exit_req;
    case (cand)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      default: pick = rr_ptr;
    endcase
    do_grant = ((state == ST_IDLE) && (|idle_req)) ||
               ((state == ST_ACCESS) && xfer_end && (|exit_req));
  end

`ifdef APB_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      to_cnt <= '0;
    end else if (state == ST_SETUP) begin
      to_cnt <= '0;
    end else if ((state == ST_ACCESS) && !apb.PREADY) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign xfer_end = apb.PREADY || (to_cnt == TO_W'(TO_CYCLES - 1));
`else
  assign xfer_end = apb.PREADY;
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= ST_IDLE;
      rr_ptr      <= 1'b0;
      win_idx     <= 1'b0;
      done        <= 2'b00;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      apb.PSEL    <= '0;
      apb.PENABLE <= 1'b0;
      apb.PADDR   <= '0;
      apb.PWRITE  <= 1'b0;
      apb.PWDATA  <= '0;
    end else begin
      done <= 2'b00;

      // A transfer that ends without PREADY was cut off by the timeout.
      if ((state == ST_ACCESS) && xfer_end) begin
        done      <= 2'b01 << win_idx;
        rsp_rdata <= (apb.PREADY && !apb.PWRITE) ? apb.PRDATA : '0;
        rsp_err   <= apb.PREADY ? apb.PSLVERR : 1'b1;
      end

      if (do_grant) begin
        state       <= ST_SETUP;
        win_idx     <= pick;
        rr_ptr      <= ~pick;
        apb.PSEL    <= SEL_ONEHOT;
        apb.PENABLE <= 1'b0;
        apb.PADDR   <= pick ? req_addr[ADDR_W +: ADDR_W]  : req_addr[0 +: ADDR_W];
        apb.PWDATA  <= pick ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
        apb.PWRITE  <= req_write[pick];
      end else begin
        case (state)
          ST_IDLE: ;
          ST_SETUP: begin
            state       <= ST_ACCESS;
            apb.PENABLE <= 1'b1;
          end
          ST_ACCESS: begin
            if (xfer_end) begin
              state       <= ST_IDLE;
              apb.PSEL    <= '0;
              apb.PENABLE <= 1'b0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
